arc4_ctrl: RTL and testbench
============================

// Module: arc4_ctrl
// PURPOSE
//  Sequences the ARC4 datapath: init -> ksa -> prga, one en/rdy handshake per phase.
//  Owns the single S-memory write port and grants it to exactly one phase engine at a time.
//  Latches the 24-bit key for ksa, runs a per-phase watchdog and flags protocol faults.
//  Sits between the arc4 top-level handshake and the init/ksa/prga engines plus s_mem.
// PARAMETERS
//  KEY_W   24  key width forwarded to ksa
//  WDOG_W  12  per-phase watchdog width; timeout after 2**WDOG_W-1 cycles in one phase
// PORTS
//  clk          in   1      single clock, all state on rising edge
//  rst          in   1      asynchronous reset, active-high
//  en           in   1      start request; honoured only while rdy=1
//  rdy          out  1      idle, ready for en
//  key          in   KEY_W  key; sampled on accepted en
//  key_q        out  KEY_W  latched key to ksa
//  err          out  1      sticky fault: watchdog timeout or foreign write
//  init_en/ksa_en/prga_en     out 1  one-cycle start pulses to engines
//  init_rdy/ksa_rdy/prga_rdy  in  1  engine ready/done
//  {init,ksa,prga}_addr    in 8  engine S-memory address
//  {init,ksa,prga}_wrdata  in 8  engine write data
//  {init,ksa,prga}_wren    in 1  engine write enable
//  s_addr       out  8      to s_mem
//  s_wrdata     out  8      to s_mem
//  s_wren       out  1      to s_mem
// BEHAVIOUR
//  Reset (async): state=IDLE, owner=NONE, rdy=0, err=0, key_q=0, all *_en=0, wdog=0.
//   rdy is registered; rises on first clk edge after rst deasserts.
//  Handshake: en sampled when rdy=1 -> rdy=0 next cycle, key_q<=key, err<=0.
//   en while rdy=0 ignored. rdy returns to 1 one cycle after the DONE state.
//  FSM per phase X in {INIT,KSA,PRGA}: X_START -> X_ACK -> X_WAIT.
//   X_START: wait for X_rdy=1, then pulse X_en for exactly 1 cycle, owner<=X.
//   X_ACK: wait for X_rdy=0 (engine accepted); never treat stale rdy as done.
//   X_WAIT: on X_rdy=1 -> next phase START (PRGA_WAIT -> DONE).
//   DONE: owner<=NONE, rdy<=1, -> IDLE.
//  Sequence: IDLE -en-> INIT_START ... PRGA_WAIT -> DONE -> IDLE.
//  Minimum total latency: 3 phases x 3 cycles + engine run time + 1 (DONE).
//  Port mux: combinational from registered owner; owner=NONE -> s_addr=0,
//   s_wrdata=0, s_wren=0. Owner changes only on the X_START -> X_ACK transition.
//  Foreign write: any non-owner *_wren=1 -> masked (never reaches s_mem), err<=1.
//  Watchdog: clears on every phase transition, increments each cycle in
//   X_START/X_ACK/X_WAIT; saturating at all-ones -> FAULT.
//  FAULT: owner<=NONE, all *_en=0, err<=1, -> IDLE with rdy=1 next cycle.
//   err holds until the next accepted en.
//  Simultaneous: en and rst -> rst wins. Foreign write in the same cycle as a
//   timeout -> FAULT, err=1 (single flag).
//  Reset mid-phase: immediate return to reset values; engines share rst and restart.
// STRUCTURE
//  arc4_pkg: ctrl_state_t enum (IDLE, INIT_START, INIT_ACK, INIT_WAIT,
//   KSA_START, KSA_ACK, KSA_WAIT, PRGA_START, PRGA_ACK, PRGA_WAIT, DONE, FAULT),
//   owner_t enum (NONE, INIT, KSA, PRGA), KEY_W, S_AW=8, S_DW=8.
//  Sub-module s_port_mux: owner_t select + 3 request ports -> s_mem port +
//   foreign_wr flag.
//  FSM, key latch and watchdog stay in arc4_ctrl.
// TESTING
//  1 Reset: rst=1 for 2 cycles -> rdy=0, s_wren=0, err=0.
//    Deassert -> rdy=1 after 1 edge.
//  2 Happy path, key=24'h00033C, engine models ready after 256/768/N cycles:
//    - one pulse each on init_en, ksa_en, prga_en, in that order;
//    - key_q=24'h00033C;
//    - rdy=1 one cycle after prga_rdy rises; err=0.
//  3 Ownership: during KSA, init_wren=1 with addr 8'h10:
//    - s_wren follows ksa_wren only; s_addr=ksa_addr;
//    - err=1 at end of run.
//  4 Stale rdy: engine holds rdy=1 for 3 cycles after en:
//    - FSM stays in X_ACK and does not advance until rdy drops.
//  5 Watchdog, WDOG_W=4: ksa_rdy stuck 0
//    - FAULT after 15 cycles in KSA_WAIT; err=1; rdy=1; s_wren=0;
//    - new en clears err.
//  6 Mid-run reset: rst at cycle 40 of KSA
//    - outputs return to reset values that cycle, no *_en pulse;
//    - en is ignored while rdy=0.

Source files
------------

// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 controller slice.
//   ctrl_state_t : sequencer states (three phases of START/ACK/WAIT, DONE, FAULT)
//   owner_t      : which phase engine currently holds the S-memory write port
//   KEY_W        : default key width forwarded to ksa
//   S_AW / S_DW  : S-memory address / data widths
package arc4_pkg;

  localparam int KEY_W = 24;
  localparam int S_AW  = 8;
  localparam int S_DW  = 8;

  typedef enum logic [3:0] {
    IDLE,
    INIT_START,
    INIT_ACK,
    INIT_WAIT,
    KSA_START,
    KSA_ACK,
    KSA_WAIT,
    PRGA_START,
    PRGA_ACK,
    PRGA_WAIT,
    DONE,
    FAULT
  } ctrl_state_t;

  typedef enum logic [1:0] {
    NONE,
    INIT,
    KSA,
    PRGA
  } owner_t;

endpackage

// File: rtl/arc4_ctrl_if.sv
// Bundle of every arc4_ctrl signal except clk/rst.
//   host side   : en, key -> controller; rdy, key_q, err <- controller
//   engine side : *_rdy, *_addr, *_wrdata, *_wren -> controller; *_en <- controller
//   s_mem side  : s_addr, s_wrdata, s_wren <- controller
// Modports: slave = the controller, master = everything around it.
interface arc4_ctrl_if #(
  parameter int KEY_W = arc4_pkg::KEY_W
);

  logic                      en;
  logic                      rdy;
  logic [KEY_W-1:0]          key;
  logic [KEY_W-1:0]          key_q;
  logic                      err;

  logic                      init_en;
  logic                      ksa_en;
  logic                      prga_en;
  logic                      init_rdy;
  logic                      ksa_rdy;
  logic                      prga_rdy;

  logic [arc4_pkg::S_AW-1:0] init_addr;
  logic [arc4_pkg::S_AW-1:0] ksa_addr;
  logic [arc4_pkg::S_AW-1:0] prga_addr;
  logic [arc4_pkg::S_DW-1:0] init_wrdata;
  logic [arc4_pkg::S_DW-1:0] ksa_wrdata;
  logic [arc4_pkg::S_DW-1:0] prga_wrdata;
  logic                      init_wren;
  logic                      ksa_wren;
  logic                      prga_wren;

  logic [arc4_pkg::S_AW-1:0] s_addr;
  logic [arc4_pkg::S_DW-1:0] s_wrdata;
  logic                      s_wren;

  modport slave (
    input  en, key,
    output rdy, key_q, err,
    output init_en, ksa_en, prga_en,
    input  init_rdy, ksa_rdy, prga_rdy,
    input  init_addr, ksa_addr, prga_addr,
    input  init_wrdata, ksa_wrdata, prga_wrdata,
    input  init_wren, ksa_wren, prga_wren,
    output s_addr, s_wrdata, s_wren
  );

  modport master (
    output en, key,
    input  rdy, key_q, err,
    input  init_en, ksa_en, prga_en,
    output init_rdy, ksa_rdy, prga_rdy,
    output init_addr, ksa_addr, prga_addr,
    output init_wrdata, ksa_wrdata, prga_wrdata,
    output init_wren, ksa_wren, prga_wren,
    input  s_addr, s_wrdata, s_wren
  );

endinterface

// File: rtl/arc4_ctrl_s_port_mux.sv
// S-memory write-port multiplexer.
//   owner                    : registered grant from the sequencer
//   {init,ksa,prga}_{addr,wrdata,wren} : engine requests
//   s_addr/s_wrdata/s_wren   : single port to s_mem (all zero when owner=NONE)
//   foreign_wr               : a non-owner engine asserted its write enable
// Purely combinational; a non-owner write never reaches s_mem.
module s_port_mux
  import arc4_pkg::*;
(
  input  owner_t          owner,
  input  logic [S_AW-1:0] init_addr,
  input  logic [S_DW-1:0] init_wrdata,
  input  logic            init_wren,
  input  logic [S_AW-1:0] ksa_addr,
  input  logic [S_DW-1:0] ksa_wrdata,
  input  logic            ksa_wren,
  input  logic [S_AW-1:0] prga_addr,
  input  logic [S_DW-1:0] prga_wrdata,
  input  logic            prga_wren,
  output logic [S_AW-1:0] s_addr,
  output logic [S_DW-1:0] s_wrdata,
  output logic            s_wren,
  output logic            foreign_wr
);

  always_comb begin
    s_addr   = '0;
    s_wrdata = '0;
    s_wren   = 1'b0;
    case (owner)
      INIT: begin
        s_addr   = init_addr;
        s_wrdata = init_wrdata;
        s_wren   = init_wren;
      end
      KSA: begin
        s_addr   = ksa_addr;
        s_wrdata = ksa_wrdata;
        s_wren   = ksa_wren;
      end
      PRGA: begin
        s_addr   = prga_addr;
        s_wrdata = prga_wrdata;
        s_wren   = prga_wren;
      end
      default: ;
    endcase
  end

  assign foreign_wr = (init_wren && (owner != INIT)) ||
                      (ksa_wren  && (owner != KSA))  ||
                      (prga_wren && (owner != PRGA));

endmodule

// File: rtl/arc4_ctrl.sv
// ARC4 sequencer: runs init -> ksa -> prga with one en/rdy handshake per
// phase, grants the S-memory write port to the active engine, latches the key
// and watches each phase with a saturating watchdog.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : arc4_ctrl_if.slave (host handshake, engine control, s_mem port)
// Parameters: KEY_W key width, WDOG_W watchdog width (timeout after
// 2**WDOG_W-1 cycles spent in one phase state).
module arc4_ctrl
  import arc4_pkg::*;
#(
  parameter int KEY_W  = arc4_pkg::KEY_W,
  parameter int WDOG_W = 12
) (
  input  logic        clk,
  input  logic        rst,
  arc4_ctrl_if.slave  bus
);

  localparam logic [WDOG_W-1:0] WDOG_MAX = {WDOG_W{1'b1}};

  ctrl_state_t       state_q, state_nxt;
  owner_t            owner_q, owner_nxt;
  logic              rdy_q, rdy_nxt;
  logic              err_q, err_nxt;
  logic [KEY_W-1:0]  key_r, key_nxt;
  logic [WDOG_W-1:0] wdog_q, wdog_nxt, wdog_inc;
  logic              init_en_q, init_en_nxt;
  logic              ksa_en_q, ksa_en_nxt;
  logic              prga_en_q, prga_en_nxt;
  logic              in_phase;
  logic              foreign_wr;

  s_port_mux u_mux (
    .owner       (owner_q),
    .init_addr   (bus.init_addr),
    .init_wrdata (bus.init_wrdata),
    .init_wren   (bus.init_wren),
    .ksa_addr    (bus.ksa_addr),
    .ksa_wrdata  (bus.ksa_wrdata),
    .ksa_wren    (bus.ksa_wren),
    .prga_addr   (bus.prga_addr),
    .prga_wrdata (bus.prga_wrdata),
    .prga_wren   (bus.prga_wren),
    .s_addr      (bus.s_addr),
    .s_wrdata    (bus.s_wrdata),
    .s_wren      (bus.s_wren),
    .foreign_wr  (foreign_wr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= NONE;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
      key_r     <= '0;
      wdog_q    <= '0;
      init_en_q <= 1'b0;
      ksa_en_q  <= 1'b0;
      prga_en_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      owner_q   <= owner_nxt;
      rdy_q     <= rdy_nxt;
      err_q     <= err_nxt;
      key_r     <= key_nxt;
      wdog_q    <= wdog_nxt;
      init_en_q <= init_en_nxt;
      ksa_en_q  <= ksa_en_nxt;
      prga_en_q <= prga_en_nxt;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    owner_nxt   = owner_q;
    rdy_nxt     = rdy_q;
    err_nxt     = err_q;
    key_nxt     = key_r;
    wdog_nxt    = '0;
    wdog_inc    = wdog_q + 1'b1;
    init_en_nxt = 1'b0;
    ksa_en_nxt  = 1'b0;
    prga_en_nxt = 1'b0;
    in_phase    = state_q inside {INIT_START, INIT_ACK, INIT_WAIT,
                                  KSA_START,  KSA_ACK,  KSA_WAIT,
                                  PRGA_START, PRGA_ACK, PRGA_WAIT};

    case (state_q)
      IDLE: begin
        if (rdy_q && bus.en) begin
          state_nxt = INIT_START;
          rdy_nxt   = 1'b0;
          key_nxt   = bus.key;
          err_nxt   = 1'b0;
        end else begin
          rdy_nxt   = 1'b1;
        end
      end
      // The grant moves only together with the start pulse, so an engine
      // owns the port from the cycle it is told to start.
      INIT_START: if (bus.init_rdy) begin
        state_nxt   = INIT_ACK;
        owner_nxt   = INIT;
        init_en_nxt = 1'b1;
      end
      // A ready still high from before the start pulse is not completion;
      // wait for the engine to drop it first.
      INIT_ACK:   if (!bus.init_rdy) state_nxt = INIT_WAIT;
      INIT_WAIT:  if (bus.init_rdy)  state_nxt = KSA_START;
      KSA_START: if (bus.ksa_rdy) begin
        state_nxt  = KSA_ACK;
        owner_nxt  = KSA;
        ksa_en_nxt = 1'b1;
      end
      KSA_ACK:    if (!bus.ksa_rdy)  state_nxt = KSA_WAIT;
      KSA_WAIT:   if (bus.ksa_rdy)   state_nxt = PRGA_START;
      PRGA_START: if (bus.prga_rdy) begin
        state_nxt   = PRGA_ACK;
        owner_nxt   = PRGA;
        prga_en_nxt = 1'b1;
      end
      PRGA_ACK:   if (!bus.prga_rdy) state_nxt = PRGA_WAIT;
      PRGA_WAIT:  if (bus.prga_rdy)  state_nxt = DONE;
      DONE: begin
        owner_nxt = NONE;
        rdy_nxt   = 1'b1;
        state_nxt = IDLE;
      end
      FAULT: begin
        owner_nxt = NONE;
        err_nxt   = 1'b1;
        rdy_nxt   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Watchdog restarts on every state change and trips when the count
    // would saturate while the state is still unchanged.
    if (in_phase && (state_nxt == state_q)) begin
      if (wdog_inc == WDOG_MAX) begin
        state_nxt = FAULT;
      end else begin
        wdog_nxt  = wdog_inc;
      end
    end

    // A foreign write is flagged even on the cycle a new run is accepted.
    if (foreign_wr) err_nxt = 1'b1;
  end

  assign bus.rdy     = rdy_q;
  assign bus.err     = err_q;
  assign bus.key_q   = key_r;
  assign bus.init_en = init_en_q;
  assign bus.ksa_en  = ksa_en_q;
  assign bus.prga_en = prga_en_q;

endmodule

// File: tb/tb_arc4_ctrl.sv
// Testbench for arc4_ctrl: table of full runs against behavioural engines,
// plus hand-written watchdog and mid-run reset sequences.
module tb_arc4_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arc4_ctrl_if #(.KEY_W(24)) bus ();
  arc4_ctrl_if #(.KEY_W(24)) wbus ();

  arc4_ctrl #(.KEY_W(24), .WDOG_W(12)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  arc4_ctrl #(.KEY_W(24), .WDOG_W(4))  u_wdt (.clk(clk), .rst(rst), .bus(wbus));

  // ---------------- stimulus variables ----------------
  logic        drv_en;
  logic [23:0] drv_key;
  logic        w_en, w_init_rdy, w_ksa_rdy, w_ksa_wren;

  int   lat[3];
  int   stale[3];
  logic inj_en;

  // ---------------- engine models (react on negedge) ----------------
  int         ph[3];
  int         left[3];
  int         cnt[3];
  logic       erdy[3];
  logic       ewren[3];
  logic [7:0] eaddr[3];
  logic [7:0] edata[3];
  logic       inj;

  always @(negedge clk) begin
    logic [2:0] env;
    env = {bus.prga_en, bus.ksa_en, bus.init_en};
    for (int e = 0; e < 3; e++) begin
      if (rst) begin
        ph[e]   = 0;
        left[e] = 0;
        cnt[e]  = 0;
        erdy[e] = 1'b1;
      end else begin
        if (ph[e] == 0 && env[e]) begin
          ph[e]   = 1;
          left[e] = stale[e];
        end
        if (ph[e] == 1) begin
          if (left[e] == 0) begin
            erdy[e] = 1'b0;
            ph[e]   = 2;
            cnt[e]  = lat[e];
          end else begin
            left[e] = left[e] - 1;
          end
        end else if (ph[e] == 2) begin
          if (cnt[e] == 0) begin
            erdy[e] = 1'b1;
            ph[e]   = 0;
          end else begin
            cnt[e] = cnt[e] - 1;
          end
        end
      end
      ewren[e] = (ph[e] == 2);
      eaddr[e] = 8'(cnt[e]);
      edata[e] = 8'(cnt[e] * 3 + e + 1);
    end
    inj = inj_en && (ph[1] == 2) && (cnt[1] > 2) && (cnt[1] < 8);
  end

  assign bus.en          = drv_en;
  assign bus.key         = drv_key;
  assign bus.init_rdy    = erdy[0];
  assign bus.ksa_rdy     = erdy[1];
  assign bus.prga_rdy    = erdy[2];
  assign bus.init_wren   = ewren[0] | inj;
  assign bus.init_addr   = inj ? 8'h10 : eaddr[0];
  assign bus.init_wrdata = inj ? 8'hEE : edata[0];
  assign bus.ksa_wren    = ewren[1];
  assign bus.ksa_addr    = eaddr[1];
  assign bus.ksa_wrdata  = edata[1];
  assign bus.prga_wren   = ewren[2];
  assign bus.prga_addr   = eaddr[2];
  assign bus.prga_wrdata = edata[2];

  assign wbus.en          = w_en;
  assign wbus.key         = 24'h0000A1;
  assign wbus.init_rdy    = w_init_rdy;
  assign wbus.ksa_rdy     = w_ksa_rdy;
  assign wbus.prga_rdy    = 1'b1;
  assign wbus.init_wren   = 1'b0;
  assign wbus.init_addr   = 8'h00;
  assign wbus.init_wrdata = 8'h00;
  assign wbus.ksa_wren    = w_ksa_wren;
  assign wbus.ksa_addr    = 8'h33;
  assign wbus.ksa_wrdata  = 8'h44;
  assign wbus.prga_wren   = 1'b0;
  assign wbus.prga_addr   = 8'h00;
  assign wbus.prga_wrdata = 8'h00;

  // ---------------- start-pulse monitor ----------------
  int cyc = 0;
  int pcnt[3];
  int plast[3];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.init_en) begin pcnt[0] = pcnt[0] + 1; plast[0] = cyc; end
    if (bus.ksa_en)  begin pcnt[1] = pcnt[1] + 1; plast[1] = cyc; end
    if (bus.prga_en) begin pcnt[2] = pcnt[2] + 1; plast[2] = cyc; end
  end

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [23:0] key;
    int          li;
    int          lk;
    int          lp;
    int          sk;
    bit          inj;
    int          exp_lat;
    bit          exp_err;
  } vec_t;

  vec_t tbl[4];

  task automatic run_vec(input vec_t v);
    int n;
    int c0[3];
    bit done;
    lat[0] = v.li; lat[1] = v.lk; lat[2] = v.lp;
    stale[0] = 0; stale[1] = v.sk; stale[2] = 0;
    inj_en = v.inj;
    for (int e = 0; e < 3; e++) c0[e] = pcnt[e];
    @(posedge clk); #1;
    drv_en  = 1'b1;
    drv_key = v.key;
    @(posedge clk); #1;
    drv_en  = 1'b0;
    drv_key = 24'hFFFFFF;
    chk("accept_rdy", 32'(bus.rdy), 32'd0);
    chk("accept_key_q", 32'(bus.key_q), 32'(v.key));
    chk("accept_err", 32'(bus.err), 32'd0);
    n = 0;
    done = 1'b0;
    while (!done && n < 5000) begin
      @(posedge clk); #1;
      n++;
      if (inj) begin
        chk("own_s_wren", 32'(bus.s_wren), 32'(ewren[1]));
        chk("own_s_addr", 32'(bus.s_addr), 32'(eaddr[1]));
        chk("own_s_wrdata", 32'(bus.s_wrdata), 32'(edata[1]));
      end
      if (bus.rdy) done = 1'b1;
    end
    chk("latency", 32'(n), 32'(v.exp_lat));
    chk("init_en_pulses", 32'(pcnt[0] - c0[0]), 32'd1);
    chk("ksa_en_pulses", 32'(pcnt[1] - c0[1]), 32'd1);
    chk("prga_en_pulses", 32'(pcnt[2] - c0[2]), 32'd1);
    chk("order_init_ksa", 32'(plast[0] < plast[1]), 32'd1);
    chk("order_ksa_prga", 32'(plast[1] < plast[2]), 32'd1);
    chk("end_err", 32'(bus.err), 32'(v.exp_err));
    chk("end_key_q", 32'(bus.key_q), 32'(v.key));
    inj_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int psum;
    for (int e = 0; e < 3; e++) begin
      pcnt[e] = 0; plast[e] = 0; lat[e] = 0; stale[e] = 0;
    end
    inj_en = 1'b0;
    drv_en = 1'b0; drv_key = 24'h0;
    w_en = 1'b0; w_init_rdy = 1'b1; w_ksa_rdy = 1'b1; w_ksa_wren = 1'b0;

    //      key           init ksa  prga stale inj latency err
    tbl[0] = '{24'h00033C, 256, 768, 64,  0,    0,  1098,   0};
    tbl[1] = '{24'hA5A5A5, 8,   16,  8,   0,    1,  42,     1};
    tbl[2] = '{24'h123456, 4,   8,   4,   3,    0,  29,     0};
    tbl[3] = '{24'h000000, 0,   0,   0,   0,    0,  10,     0};

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", 32'(bus.rdy), 32'd0);
    chk("rst_s_wren", 32'(bus.s_wren), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_key_q", 32'(bus.key_q), 32'd0);
    chk("rst_en_pulses", 32'({bus.init_en, bus.ksa_en, bus.prga_en}), 32'd0);
    rst = 1'b0;
    #1;
    chk("rdy_before_edge", 32'(bus.rdy), 32'd0);
    @(posedge clk); #1;
    chk("rdy_after_edge", 32'(bus.rdy), 32'd1);
    chk("wdt_rdy_after_edge", 32'(wbus.rdy), 32'd1);

    // Full runs from the table
    for (int i = 0; i < 4; i++) run_vec(tbl[i]);

    // Watchdog on the WDOG_W=4 instance, engines driven by hand
    @(posedge clk); #1;
    w_en = 1'b1;
    @(posedge clk); #1;
    w_en = 1'b0;
    chk("wd_accept_rdy", 32'(wbus.rdy), 32'd0);
    @(posedge clk); #1;
    chk("wd_init_en", 32'(wbus.init_en), 32'd1);
    w_init_rdy = 1'b0;
    @(posedge clk); #1;
    w_init_rdy = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("wd_ksa_en", 32'(wbus.ksa_en), 32'd1);
    w_ksa_rdy  = 1'b0;
    w_ksa_wren = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    chk("wd_fault_rdy", 32'(wbus.rdy), 32'd0);
    chk("wd_fault_err", 32'(wbus.err), 32'd0);
    @(posedge clk); #1;
    chk("wd_idle_rdy", 32'(wbus.rdy), 32'd1);
    chk("wd_idle_err", 32'(wbus.err), 32'd1);
    chk("wd_idle_s_wren", 32'(wbus.s_wren), 32'd0);
    w_ksa_wren = 1'b0;
    w_en       = 1'b1;
    @(posedge clk); #1;
    w_en = 1'b0;
    chk("wd_new_en_err", 32'(wbus.err), 32'd0);
    chk("wd_new_en_rdy", 32'(wbus.rdy), 32'd0);
    w_ksa_rdy = 1'b1;

    // Reset in the middle of KSA
    lat[0] = 256; lat[1] = 768; lat[2] = 64;
    stale[1] = 0;
    @(posedge clk); #1;
    drv_en = 1'b1; drv_key = 24'hABCDEF;
    @(posedge clk); #1;
    drv_en = 1'b0;
    n = 0;
    while (!bus.ksa_en && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mr_ksa_started", 32'(bus.ksa_en), 32'd1);
    repeat (40) @(posedge clk);
    #1;
    psum = pcnt[0] + pcnt[1] + pcnt[2];
    rst    = 1'b1;
    drv_en = 1'b1;
    #1;
    chk("mr_rdy", 32'(bus.rdy), 32'd0);
    chk("mr_err", 32'(bus.err), 32'd0);
    chk("mr_key_q", 32'(bus.key_q), 32'd0);
    chk("mr_s_wren", 32'(bus.s_wren), 32'd0);
    chk("mr_en_pulses", 32'({bus.init_en, bus.ksa_en, bus.prga_en}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("mr_hold_rdy", 32'(bus.rdy), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mr_release_rdy", 32'(bus.rdy), 32'd1);
    drv_en = 1'b0;
    @(posedge clk); #1;
    chk("mr_still_idle_rdy", 32'(bus.rdy), 32'd1);
    chk("mr_no_pulse", 32'(pcnt[0] + pcnt[1] + pcnt[2] - psum), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
